// File: rtl/mac_operand_loader_pkg.sv
// Shared constants and state encodings for the MAC operand loader.
// Both operand loaders and the launch FSM import this package.
package mac_operand_loader_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int CHANNEL_DEPTH = 32;

  function automatic int C_LOG_2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int IDX_W = C_LOG_2(CHANNEL_DEPTH);

  typedef enum logic [1:0] {
    LD_HDR  = 2'd0,
    LD_DAT  = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

  typedef enum logic [1:0] {
    LN_IDLE   = 2'd0,
    LN_LAUNCH = 2'd1,
    LN_GUARD  = 2'd2,
    LN_WAIT   = 2'd3
  } ln_state_t;

endpackage

// File: rtl/mac_operand_loader_opnd_unpack.sv
// One sparse-to-dense operand loader: header carries the non-zero mask, data
// beats fill flagged slots in ascending order into the shadow buffer.
module opnd_unpack
  import mac_operand_loader_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                vld,
  output logic                                rdy,
  input  logic                                hdr,
  input  logic [CHANNEL_DEPTH-1:0]            flg,
  input  logic [DATA_WIDTH-1:0]               dat,
  input  logic                                launch,
  output logic                                done,
  output logic                                err,
  output logic [CHANNEL_DEPTH-1:0]            shd_flg,
  output logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] shd_dat
);

  ld_state_t                 state_reg, state_next;
  logic [CHANNEL_DEPTH-1:0]  pend_reg, pend_next;
  logic [CHANNEL_DEPTH-1:0]  flg_reg;
  logic [DATA_WIDTH-1:0]     dat_reg [CHANNEL_DEPTH];
  logic [IDX_W-1:0]          slot;
  logic [CHANNEL_DEPTH-1:0]  slot_hot;
  logic                      accept;
  logic                      hdr_load;
  logic                      dat_load;

  assign rdy     = (state_reg != LD_DONE);
  assign done    = (state_reg == LD_DONE);
  assign accept  = vld && rdy;
  assign shd_flg = flg_reg;

  // Lowest pending slot wins: scanning downward leaves the smallest index.
  always_comb begin
    slot = '0;
    for (int i = CHANNEL_DEPTH - 1; i >= 0; i--) begin
      if (pend_reg[i]) slot = IDX_W'(i);
    end
  end

  assign slot_hot = {{(CHANNEL_DEPTH-1){1'b0}}, 1'b1} << slot;

  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    err        = 1'b0;
    hdr_load   = 1'b0;
    dat_load   = 1'b0;
    case (state_reg)
      LD_HDR: begin
        if (accept) begin
          if (hdr) begin
            hdr_load   = 1'b1;
            pend_next  = flg;
            state_next = (flg == '0) ? LD_DONE : LD_DAT;
          end else begin
            err = 1'b1;
          end
        end
      end
      LD_DAT: begin
        if (accept) begin
          if (!hdr) begin
            dat_load  = 1'b1;
            pend_next = pend_reg & ~slot_hot;
            if ((pend_reg & ~slot_hot) == '0) state_next = LD_DONE;
          end else begin
            err = 1'b1;
          end
        end
      end
      LD_DONE: begin
        if (launch) state_next = LD_HDR;
      end
      default: state_next = LD_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LD_HDR;
      pend_reg  <= '0;
      flg_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      if (hdr_load) flg_reg <= flg;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNEL_DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dat_reg[gi] <= '0;
        end else if (hdr_load) begin
          dat_reg[gi] <= '0;
        end else if (dat_load && (slot == IDX_W'(gi))) begin
          dat_reg[gi] <= dat;
        end
      end
      assign shd_dat[gi*DATA_WIDTH +: DATA_WIDTH] = dat_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/mac_operand_loader.sv
// MAC lane feeder: two sparse operand loaders fill shadow buffers, the launch
// FSM copies them into the active buffer and handshakes with the MAC.
module mac_operand_loader
  import mac_operand_loader_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                act_vld,
  output logic                                act_rdy,
  input  logic                                act_hdr,
  input  logic [CHANNEL_DEPTH-1:0]            act_flg,
  input  logic [DATA_WIDTH-1:0]               act_dat,
  input  logic                                wei_vld,
  output logic                                wei_rdy,
  input  logic                                wei_hdr,
  input  logic [CHANNEL_DEPTH-1:0]            wei_flg,
  input  logic [DATA_WIDTH-1:0]               wei_dat,
  output logic                                mac_sta,
  input  logic                                mac_fnh,
  output logic [CHANNEL_DEPTH-1:0]            mac_flg_act,
  output logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] mac_act,
  output logic [CHANNEL_DEPTH-1:0]            mac_flg_wei,
  output logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] mac_wei,
  output logic                                busy,
  output logic                                proto_err
);

  ln_state_t                          state_reg, state_next;
  logic                               launch;
  logic                               act_done, wei_done;
  logic                               act_err, wei_err;
  logic [CHANNEL_DEPTH-1:0]           act_shd_flg, wei_shd_flg;
  logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] act_shd_dat, wei_shd_dat;

  opnd_unpack u_act (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld     (act_vld),
    .rdy     (act_rdy),
    .hdr     (act_hdr),
    .flg     (act_flg),
    .dat     (act_dat),
    .launch  (launch),
    .done    (act_done),
    .err     (act_err),
    .shd_flg (act_shd_flg),
    .shd_dat (act_shd_dat)
  );

  opnd_unpack u_wei (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld     (wei_vld),
    .rdy     (wei_rdy),
    .hdr     (wei_hdr),
    .flg     (wei_flg),
    .dat     (wei_dat),
    .launch  (launch),
    .done    (wei_done),
    .err     (wei_err),
    .shd_flg (wei_shd_flg),
    .shd_dat (wei_shd_dat)
  );

  assign launch  = (state_reg == LN_IDLE) && act_done && wei_done;
  assign mac_sta = (state_reg == LN_LAUNCH);
  assign busy    = (state_reg != LN_IDLE);

  // GUARD exists so a finish level left over from the previous block is never
  // mistaken for completion of the one just launched.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LN_IDLE:   if (launch) state_next = LN_LAUNCH;
      LN_LAUNCH: state_next = LN_GUARD;
      LN_GUARD:  state_next = LN_WAIT;
      LN_WAIT:   if (mac_fnh) state_next = LN_IDLE;
      default:   state_next = LN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= LN_IDLE;
      mac_flg_act <= '0;
      mac_act     <= '0;
      mac_flg_wei <= '0;
      mac_wei     <= '0;
      proto_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      proto_err <= proto_err | act_err | wei_err;
      if (launch) begin
        mac_flg_act <= act_shd_flg;
        mac_act     <= act_shd_dat;
        mac_flg_wei <= wei_shd_flg;
        mac_wei     <= wei_shd_dat;
      end
    end
  end

endmodule
